// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RWAIT,
        RESP
    } apb_mst_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Low address bits that must be zero for a legal word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for the APB master bridge.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();
    // command side
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    // response side
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              rsp_timeout;
    // APB bus
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // Bridge side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output paddr, pwdata, pwrite, psel, penable
    );

    // Requester plus APB completer side
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  paddr, pwdata, pwrite, psel, penable
    );

endinterface

// File: rtl/apb_master_timer.sv
// ACCESS wait-state counter; expired flags the last permitted wait cycle.
module apb_master_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Count stalled ACCESS cycles; saturate instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt <= '0;
        else if (clr)             cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, APB transfer out,
// registered response back. All bus and response outputs are flops.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int RDATA_DELAY = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic                 pclk,
    input  logic                 preset,
    apb_master_bridge_if.master  bus
);
    apb_mst_state_t    state, state_n;
    logic [ADDR_W-1:0] paddr_q, paddr_n;
    logic [DATA_W-1:0] pwdata_q, pwdata_n;
    logic              pwrite_q, pwrite_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              err_q, err_n;
    logic              to_q, to_n;
    logic              psel_q, penable_q, rsp_valid_q;
    logic              expired;

    apb_master_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (pclk),
        .rst     (preset),
        .clr     (state == SETUP),
        .en      (state == ACCESS && !bus.pready),
        .expired (expired)
    );

    // Next state plus next values of the registered bus/response fields.
    always_comb begin
        state_n  = state;
        paddr_n  = paddr_q;
        pwdata_n = pwdata_q;
        pwrite_n = pwrite_q;
        rdata_n  = rdata_q;
        err_n    = err_q;
        to_n     = to_q;
        case (state)
            IDLE: if (bus.cmd_valid) begin
                if (is_aligned(bus.cmd_addr[1:0])) begin
                    paddr_n  = bus.cmd_addr;
                    pwdata_n = bus.cmd_wdata;
                    pwrite_n = bus.cmd_write;
                    state_n  = SETUP;
                end else begin
                    // Misaligned: answer straight away, never touch the bus.
                    rdata_n = '0;
                    err_n   = 1'b1;
                    to_n    = 1'b0;
                    state_n = RESP;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (bus.pready) begin
                    err_n   = bus.pslverr;
                    to_n    = 1'b0;
                    rdata_n = '0;
                    if (pwrite_q || RDATA_DELAY == 0) begin
                        if (!pwrite_q && !bus.pslverr) rdata_n = bus.prdata;
                        state_n = RESP;
                    end else begin
                        state_n = RWAIT;
                    end
                end else if (expired) begin
                    rdata_n = '0;
                    err_n   = 1'b1;
                    to_n    = 1'b1;
                    state_n = RESP;
                end
            end
            RWAIT: begin
                // Slave registers its read data; it is valid one cycle late.
                if (!err_q) rdata_n = bus.prdata;
                state_n = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                rdata_n = '0;
                err_n   = 1'b0;
                to_n    = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; strobes decoded from the next state.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            to_q        <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            paddr_q     <= paddr_n;
            pwdata_q    <= pwdata_n;
            pwrite_q    <= pwrite_n;
            rdata_q     <= rdata_n;
            err_q       <= err_n;
            to_q        <= to_n;
            psel_q      <= (state_n == SETUP) || (state_n == ACCESS);
            penable_q   <= (state_n == ACCESS);
            rsp_valid_q <= (state_n == RESP);
        end
    end

    assign bus.cmd_ready   = (state == IDLE) && !preset;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_error   = err_q;
    assign bus.rsp_timeout = to_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: table of transfers against a registered-
// read APB slave, scoreboard of expected responses, plus reset and
// back-pressure sequences.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .RDATA_DELAY(1), .TIMEOUT(TO)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus)
    );

    // ---------------- APB slave with registered read data ----------------
    int          s_waits;
    logic        s_stall;
    logic        s_err;
    logic [31:0] mem [0:63];
    int          acc_cnt;
    logic [31:0] prdata_r;

    assign bus.pready  = !s_stall && (acc_cnt >= s_waits);
    assign bus.pslverr = s_err;
    assign bus.prdata  = prdata_r;

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[2]   <= 32'h12349876;
            mem[4]   <= 32'h0000FFFF;
            acc_cnt  <= 0;
            prdata_r <= 32'h0;
        end else if (bus.psel && bus.penable) begin
            if (bus.pready) begin
                acc_cnt <= 0;
                if (bus.pwrite) mem[bus.paddr[7:2]] <= bus.pwdata;
                else            prdata_r <= mem[bus.paddr[7:2]];
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    // ---------------- bus monitor (cumulative counters) ----------------
    int          n_setup = 0, n_access = 0, n_unstable = 0;
    logic [31:0] s_addr, s_wdata;
    logic        s_write;

    always @(negedge pclk) begin
        if (bus.psel && !bus.penable) begin
            n_setup++;
            s_addr  = bus.paddr;
            s_wdata = bus.pwdata;
            s_write = bus.pwrite;
        end else if (bus.psel && bus.penable) begin
            n_access++;
            if (bus.paddr !== s_addr || bus.pwdata !== s_wdata || bus.pwrite !== s_write)
                n_unstable++;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        stall;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_setup;
        int          exp_access;
        int          exp_lat;
    } vec_t;

    // Present cmd now (caller is just after a negedge), wait for acceptance.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input string name, output bit ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge pclk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_accept: got no cmd_ready expected cmd_ready within 50 cycles", name);
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Wait for rsp_valid counting negedges since the accepting edge.
    task automatic wait_rsp(input string name, output bit ok, output int lat);
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            lat++;
            if (bus.rsp_valid === 1'b1) begin ok = 1'b1; break; end
        end
        chk({name, "_rsp_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge pclk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        bit   ok;
        int   lat, base_s, base_a, base_u;
        s_waits = v.waits;
        s_stall = v.stall;
        s_err   = v.slverr;
        @(negedge pclk);
        base_s = n_setup; base_a = n_access; base_u = n_unstable;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
        sb.push_back(e);
        issue(v.write, v.addr, v.wdata, name, ok);
        if (!ok) begin void'(sb.pop_back()); return; end
        bus.cmd_valid = 1'b0;
        wait_rsp(name, ok, lat);
        e = sb.pop_front();
        if (ok) begin
            chk({name, "_rdata"},   bus.rsp_rdata,          e.rdata);
            chk({name, "_error"},   32'(bus.rsp_error),     32'(e.err));
            chk({name, "_timeout"}, 32'(bus.rsp_timeout),   32'(e.to));
            chk({name, "_setups"},  32'(n_setup - base_s),  32'(v.exp_setup));
            chk({name, "_access"},  32'(n_access - base_a), 32'(v.exp_access));
            chk({name, "_latency"}, 32'(lat),               32'(v.exp_lat));
            chk({name, "_stable"},  32'(n_unstable - base_u), 32'd0);
            chk({name, "_bus_idle"}, {30'd0, bus.psel, bus.penable}, 32'd0);
            consume();
        end
        s_stall = 1'b0;
        s_err   = 1'b0;
        s_waits = 0;
    endtask

    vec_t vecs[8];

    initial begin
        bit   ok, saw;
        int   lat;
        exp_t e;

        //               wr    addr          wdata         wt stall err  rdata         er  to  su  acc lat
        vecs[0] = '{1'b0, 32'h08, 32'h0,        0, 1'b0, 1'b0, 32'h12349876, 1'b0, 1'b0, 1, 1,  4};
        vecs[1] = '{1'b1, 32'h0C, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1, 1,  3};
        vecs[2] = '{1'b0, 32'h0C, 32'h0,        0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1, 1,  4};
        vecs[3] = '{1'b0, 32'h10, 32'h0,        3, 1'b0, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1, 4,  7};
        vecs[4] = '{1'b0, 32'h04, 32'h0,        0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1, 16, 18};
        vecs[5] = '{1'b0, 32'h06, 32'h0,        0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 0, 0,  1};
        vecs[6] = '{1'b1, 32'h20, 32'h55AA55AA, 0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1, 1,  3};
        vecs[7] = '{1'b0, 32'h08, 32'h0,        1, 1'b0, 1'b0, 32'h12349876, 1'b0, 1'b0, 1, 2,  5};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        s_waits = 0;
        s_stall = 1'b0;
        s_err   = 1'b0;
        preset  = 1'b1;

        // Reset state
        @(negedge pclk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_psel",      {30'd0, bus.psel, bus.penable}, 32'd0);
        chk("rst_rsp",       {29'd0, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}, 32'd0);
        chk("rst_paddr",     bus.paddr, 32'd0);
        chk("rst_pwdata",    bus.pwdata, 32'd0);
        chk("rst_rdata",     bus.rsp_rdata, 32'd0);
        #2 preset = 1'b0;
        @(negedge pclk);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset asserted in the middle of a stalled ACCESS.
        s_waits = 5;
        @(negedge pclk);
        issue(1'b0, 32'h10, 32'h0, "rstmid", ok);
        bus.cmd_valid = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (bus.psel && bus.penable) begin saw = 1'b1; break; end
        end
        chk("rstmid_in_access", 32'(saw), 32'd1);
        #2 preset = 1'b1;
        #1;
        chk("rstmid_psel_drop", {30'd0, bus.psel, bus.penable}, 32'd0);
        chk("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge pclk);
        preset  = 1'b0;
        s_waits = 0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid) saw = 1'b1;
        end
        chk("rstmid_no_rsp", 32'(saw), 32'd0);
        run_vec(vecs[0], "after_rst");

        // Response back-pressure with a competing command held on the input.
        @(negedge pclk);
        e.rdata = 32'h0000FFFF; e.err = 1'b0; e.to = 1'b0;
        sb.push_back(e);
        issue(1'b0, 32'h10, 32'h0, "bp", ok);
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h30;
        bus.cmd_wdata = 32'h13572468;
        wait_rsp("bp", ok, lat);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid_%0d", i),     32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp_rdata_%0d", i),     bus.rsp_rdata, e.rdata);
            chk($sformatf("bp_err_%0d", i),       {30'd0, bus.rsp_error, bus.rsp_timeout}, {30'd0, e.err, e.to});
            chk($sformatf("bp_cmd_ready_%0d", i), 32'(bus.cmd_ready), 32'd0);
            chk($sformatf("bp_psel_%0d", i),      32'(bus.psel), 32'd0);
            @(negedge pclk);
        end
        bus.cmd_valid = 1'b0;
        consume();
        @(negedge pclk);
        chk("bp_released", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
        chk("bp_slave_untouched", mem[12], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
